conv3x3_single_ch: RTL and testbench

CONV3X3_SINGLE_CH -- requirements
Module: conv3x3_single_ch

---
 rtl/conv_pkg.sv | 26 ++
 rtl/q_shift_sat.sv | 36 +++
 rtl/conv3x3_single_ch.sv | 109 ++++++++++
 tb/tb_conv3x3_single_ch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg : width and saturation helpers shared by the 3x3 convolution block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam int C_NUM_TAPS = 9;

  // Nine 2*W-bit products plus the aligned bias fit in 2*W+4 bits.
  function automatic int acc_width(input int data_w);
    return 2 * data_w + 4;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_shift_sat.sv
// ----------------------------------------------------------------------------
// q_shift_sat : arithmetic right shift by FRAC (floor) then clamp to DATA_W
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module q_shift_sat
  import conv_pkg::*;
#(
  parameter int IN_W   = 20,
  parameter int DATA_W = 8,
  parameter int FRAC   = 4
) (
  input  logic signed [IN_W-1:0]   acc_i,
  output logic signed [DATA_W-1:0] data_o
);

  localparam logic signed [IN_W-1:0] C_MAX = IN_W'(sat_max(DATA_W));
  localparam logic signed [IN_W-1:0] C_MIN = IN_W'(sat_min(DATA_W));

  logic signed [IN_W-1:0] w_shr;

  always_comb begin
    w_shr = acc_i >>> FRAC;
    if (w_shr > C_MAX) begin
      data_o = C_MAX[DATA_W-1:0];
    end else if (w_shr < C_MIN) begin
      data_o = C_MIN[DATA_W-1:0];
    end else begin
      data_o = w_shr[DATA_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv3x3_single_ch.sv
// ----------------------------------------------------------------------------
// conv3x3_single_ch : 2-stage fixed-point 3x3 convolution, constant kernel
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv3x3_single_ch
  import conv_pkg::*;
#(
  parameter int                        DATA_W = 8,
  parameter int                        FRAC   = 4,
  parameter logic signed [DATA_W-1:0]  W00    = '0,
  parameter logic signed [DATA_W-1:0]  W01    = '0,
  parameter logic signed [DATA_W-1:0]  W02    = '0,
  parameter logic signed [DATA_W-1:0]  W10    = '0,
  parameter logic signed [DATA_W-1:0]  W11    = '0,
  parameter logic signed [DATA_W-1:0]  W12    = '0,
  parameter logic signed [DATA_W-1:0]  W20    = '0,
  parameter logic signed [DATA_W-1:0]  W21    = '0,
  parameter logic signed [DATA_W-1:0]  W22    = '0,
  parameter logic signed [DATA_W-1:0]  BIAS   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] p00,
  input  logic signed [DATA_W-1:0] p01,
  input  logic signed [DATA_W-1:0] p02,
  input  logic signed [DATA_W-1:0] p10,
  input  logic signed [DATA_W-1:0] p11,
  input  logic signed [DATA_W-1:0] p12,
  input  logic signed [DATA_W-1:0] p20,
  input  logic signed [DATA_W-1:0] p21,
  input  logic signed [DATA_W-1:0] p22,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid
);

  localparam int C_PROD_W = 2 * DATA_W;
  localparam int C_ACC_W  = acc_width(DATA_W);

  localparam logic signed [DATA_W-1:0] C_W [C_NUM_TAPS] =
    '{W00, W01, W02, W10, W11, W12, W20, W21, W22};
  localparam logic signed [C_ACC_W-1:0] C_BIAS_ACC = C_ACC_W'(BIAS) <<< FRAC;

  logic signed [DATA_W-1:0]   pix_d  [C_NUM_TAPS];
  logic signed [C_PROD_W-1:0] prod_d [C_NUM_TAPS];
  logic signed [C_PROD_W-1:0] prod_q [C_NUM_TAPS];
  logic                       valid1_q;
  logic signed [C_ACC_W-1:0]  acc_d;
  logic signed [DATA_W-1:0]   sat_d;
  logic signed [DATA_W-1:0]   out_data_q;
  logic                       out_valid_q;

  always_comb begin
    pix_d[0] = p00; pix_d[1] = p01; pix_d[2] = p02;
    pix_d[3] = p10; pix_d[4] = p11; pix_d[5] = p12;
    pix_d[6] = p20; pix_d[7] = p21; pix_d[8] = p22;
    for (int i = 0; i < C_NUM_TAPS; i++) begin
      prod_d[i] = C_PROD_W'(pix_d[i]) * C_PROD_W'(C_W[i]);
    end
  end

  // Valid path never looks at pixel data, so X pixels cannot reach out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= in_valid;
      if (in_valid) begin
        prod_q <= prod_d;
      end
    end
  end

  always_comb begin
    acc_d = C_BIAS_ACC;
    for (int i = 0; i < C_NUM_TAPS; i++) begin
      acc_d = acc_d + C_ACC_W'(prod_q[i]);
    end
  end

  q_shift_sat #(
    .IN_W   (C_ACC_W),
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_q_shift_sat (
    .acc_i  (acc_d),
    .data_o (sat_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= valid1_q;
      if (valid1_q) begin
        out_data_q <= sat_d;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_single_ch.sv
// ----------------------------------------------------------------------------
// tb_conv3x3_single_ch : table + random checks of two kernel instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_conv3x3_single_ch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [7:0] p [9];
  logic signed [7:0] out_a, out_b;
  logic              vld_a, vld_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  conv3x3_single_ch #(
    .DATA_W(8), .FRAC(4),
    .W00(8'sd0),   .W01(-8'sd16), .W02(8'sd0),
    .W10(-8'sd16), .W11(8'sd64),  .W12(-8'sd16),
    .W20(8'sd0),   .W21(-8'sd16), .W22(8'sd0),
    .BIAS(8'sd0)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p00(p[0]), .p01(p[1]), .p02(p[2]),
    .p10(p[3]), .p11(p[4]), .p12(p[5]),
    .p20(p[6]), .p21(p[7]), .p22(p[8]),
    .out_data(out_a), .out_valid(vld_a)
  );

  conv3x3_single_ch #(
    .DATA_W(8), .FRAC(4),
    .W00(8'sd0), .W01(8'sd0),  .W02(8'sd0),
    .W10(8'sd0), .W11(8'sd16), .W12(8'sd0),
    .W20(8'sd0), .W21(8'sd0),  .W22(8'sd0),
    .BIAS(8'sd8)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p00(p[0]), .p01(p[1]), .p02(p[2]),
    .p10(p[3]), .p11(p[4]), .p12(p[5]),
    .p20(p[6]), .p21(p[7]), .p22(p[8]),
    .out_data(out_b), .out_valid(vld_b)
  );

  typedef struct { int pix [9]; int ea; int eb; } vec_t;
  typedef struct { int due; int ea; int eb; } exp_t;

  vec_t tbl [14];
  exp_t scb [$];
  int   ka [9] = '{0, -16, 0, -16, 64, -16, 0, -16, 0};
  int   kb [9] = '{0, 0, 0, 0, 16, 0, 0, 0, 0};

  // Real-valued convolution in Q4: floor-divide by 16, then clamp to 8 bits.
  function automatic int model(input int pix [9], input int w [9], input int bias);
    int acc, m, q;
    acc = bias * 16;
    for (int i = 0; i < 9; i++) acc += pix[i] * w[i];
    m = ((acc % 16) + 16) % 16;
    q = (acc - m) / 16;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic vec_t mk(input int o, input int c, input int n, input int ea, input int eb);
    vec_t v;
    for (int i = 0; i < 9; i++) v.pix[i] = o;
    v.pix[4] = c;
    v.pix[1] = n;
    v.ea = ea;
    v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    cyc++;
    #1;
    if (r) scb.delete();
    if (scb.size() > 0 && scb[0].due == cyc) begin
      chk("valid_a", int'(vld_a), 1);
      chk("valid_b", int'(vld_b), 1);
      chk("data_a", int'(out_a), scb[0].ea);
      chk("data_b", int'(out_b), scb[0].eb);
      void'(scb.pop_front());
    end else begin
      chk("idle_valid_a", int'(vld_a), 0);
      chk("idle_valid_b", int'(vld_b), 0);
    end
  endtask

  task automatic apply(input logic r, input logic v, input int pix [9], input int ea, input int eb);
    exp_t e;
    rst = r;
    in_valid = v;
    for (int i = 0; i < 9; i++) p[i] = 8'(pix[i]);
    if (v && !r) begin
      e.due = cyc + 2;
      e.ea = ea;
      e.eb = eb;
      scb.push_back(e);
    end
    tick();
  endtask

  initial begin
    int zero [9];
    int rp [9];
    logic rv, rr;
    for (int i = 0; i < 9; i++) begin zero[i] = 0; p[i] = '0; end

    tbl[0]  = mk(16, 16, 16, 0, 24);
    tbl[1]  = mk(16, 64, 16, 127, 72);
    tbl[2]  = mk(16, -64, 16, -128, -56);
    tbl[3]  = mk(16, 20, 16, 16, 28);
    tbl[4]  = mk(0, 0, 0, 0, 8);
    tbl[5]  = mk(0, 1, 0, 4, 9);
    tbl[6]  = mk(0, -1, 0, -4, 7);
    tbl[7]  = mk(0, 3, 1, 11, 11);
    tbl[8]  = mk(0, 0, 1, -1, 8);
    tbl[9]  = mk(0, -3, 0, -12, 5);
    tbl[10] = mk(0, 0, -1, 1, 8);
    tbl[11] = mk(127, 127, 127, 0, 127);
    tbl[12] = mk(-128, -128, -128, 0, -120);
    tbl[13] = mk(-128, 127, -128, 127, 127);

    apply(1'b1, 1'b0, zero, 0, 0);
    apply(1'b1, 1'b1, zero, 0, 0);
    chk("reset_data_a", int'(out_a), 0);
    chk("reset_valid_a", int'(vld_a), 0);
    chk("reset_data_b", int'(out_b), 0);

    // Back-to-back windows straight out of reset.
    for (int k = 0; k < 14; k++) apply(1'b0, 1'b1, tbl[k].pix, tbl[k].ea, tbl[k].eb);
    repeat (3) apply(1'b0, 1'b0, zero, 0, 0);

    // Reset one cycle after a window: the window must vanish.
    apply(1'b0, 1'b1, tbl[1].pix, tbl[1].ea, tbl[1].eb);
    apply(1'b1, 1'b0, zero, 0, 0);
    chk("flush_data_a", int'(out_a), 0);
    chk("flush_valid_a", int'(vld_a), 0);
    repeat (3) apply(1'b0, 1'b0, zero, 0, 0);

    // A window with rst high is ignored, one right after is accepted.
    apply(1'b1, 1'b1, tbl[3].pix, 0, 0);
    apply(1'b0, 1'b1, tbl[9].pix, tbl[9].ea, tbl[9].eb);
    apply(1'b0, 1'b0, tbl[0].pix, 0, 0);
    apply(1'b0, 1'b0, tbl[1].pix, 0, 0);
    chk("hold_data_b", int'(out_b), 5);

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 9; i++) rp[i] = int'($signed(8'($urandom_range(0, 255))));
      if ($urandom_range(0, 3) == 0) rp[4] = ($urandom_range(0, 1) != 0) ? 127 : -128;
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 49) == 0);
      apply(rr, rv, rp, model(rp, ka, 0), model(rp, kb, 8));
    end
    repeat (4) apply(1'b0, 1'b0, zero, 0, 0);
    chk("scoreboard_drained", scb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
